// File: rtl/mac_job_ctrl_pkg.sv
// Shared types and constants for the MAC job sequencer.
package mac_job_ctrl_pkg;

    localparam int MAC_CTRL_CNT_W   = 16;
    localparam int MAC_CTRL_SHIFT_W = 5;

    // Job sequencer states.
    typedef enum logic [2:0] {
        CTRL_IDLE      = 3'd0,
        CTRL_WAIT_STRM = 3'd1,
        CTRL_RUN       = 3'd2,
        CTRL_DRAIN     = 3'd3,
        CTRL_DONE      = 3'd4
    } mac_ctrl_state_e;

    // Packed view of one job as handed over by the register file.
    typedef struct packed {
        logic [MAC_CTRL_CNT_W-1:0]   len;
        logic [MAC_CTRL_CNT_W-1:0]   nout;
        logic                        simple_mul;
        logic [MAC_CTRL_SHIFT_W-1:0] shift;
    } mac_ctrl_cfg_t;

    // Even parity over a job descriptor, for register-file side protection.
    function automatic logic cfg_parity(input mac_ctrl_cfg_t cfg);
        return ^cfg;
    endfunction

endpackage

// File: rtl/mac_job_ctrl_beat.sv
// Saturating beat counter with synchronous clear, enable and a look-ahead
// "target reached" flag that already accounts for this cycle's increment.
module mac_beat_counter
    import mac_job_ctrl_pkg::*;
#(
    parameter int CNT_W = MAC_CTRL_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_target,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_reached_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_inc;

    // Next count: clear wins, beats beyond the target or at saturation are dropped.
    always_comb begin
        w_inc = i_en && (r_cnt < i_target) && (r_cnt != CNT_MAX);
        if (i_clr) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (w_inc) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= CNT_ZERO;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt         = r_cnt;
    assign o_reached_nxt = (w_cnt_nxt >= i_target);

endmodule

// File: rtl/mac_job_ctrl.sv
// MAC job sequencer: latches a job, launches the streamers, keeps the
// datapath started while beats flow, and flags the end of the job.
module mac_job_ctrl
    import mac_job_ctrl_pkg::*;
#(
    parameter int CNT_W   = MAC_CTRL_CNT_W,
    parameter int SHIFT_W = MAC_CTRL_SHIFT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               cfg_start_i,
    input  logic [CNT_W-1:0]   cfg_len_i,
    input  logic [CNT_W-1:0]   cfg_nout_i,
    input  logic               cfg_simple_mul_i,
    input  logic [SHIFT_W-1:0] cfg_shift_i,
    input  logic               strm_ready_i,
    output logic               strm_req_o,
    input  logic               ab_hs_i,
    input  logic               d_hs_i,
    output logic               eng_start_o,
    output logic               eng_simple_mul_o,
    output logic [SHIFT_W-1:0] eng_shift_o,
    output logic               busy_o,
    output logic               evt_done_o,
    output logic [CNT_W-1:0]   cnt_ab_o,
    output logic [CNT_W-1:0]   cnt_d_o
);

    localparam logic [CNT_W-1:0]   LEN_ZERO   = {CNT_W{1'b0}};
    localparam logic [SHIFT_W-1:0] SHIFT_ZERO = {SHIFT_W{1'b0}};

    mac_ctrl_state_e    r_state;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_nout;
    logic               r_simple_mul;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_eng_start;
    logic               r_busy;
    logic               r_evt_done;

    logic               w_accept;
    logic               w_cnt_clr;
    logic               w_ab_en;
    logic               w_d_en;
    logic [CNT_W-1:0]   w_d_target;
    logic               w_ab_reached;
    logic               w_d_reached;
    logic               w_strm_req;

    // Qualifiers for the beat counters and the streamer launch handshake.
    always_comb begin
        w_accept   = (r_state == CTRL_IDLE) && cfg_start_i;
        w_cnt_clr  = clear_i || w_accept;
        w_ab_en    = (r_state == CTRL_RUN) && ab_hs_i;
        w_d_en     = ((r_state == CTRL_RUN) || (r_state == CTRL_DRAIN)) && d_hs_i;
        w_d_target = r_simple_mul ? r_len : r_nout;
        // Launch is a same-cycle answer to strm_ready_i so the streamers start
        // exactly when they report idle; zero-length jobs never launch.
        w_strm_req = (r_state == CTRL_WAIT_STRM) && strm_ready_i &&
                     (r_len != LEN_ZERO) && !clear_i;
    end

    mac_beat_counter #(.CNT_W(CNT_W)) u_cnt_ab (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_clr         (w_cnt_clr),
        .i_en          (w_ab_en),
        .i_target      (r_len),
        .o_cnt         (cnt_ab_o),
        .o_reached_nxt (w_ab_reached)
    );

    mac_beat_counter #(.CNT_W(CNT_W)) u_cnt_d (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_clr         (w_cnt_clr),
        .i_en          (w_d_en),
        .i_target      (w_d_target),
        .o_cnt         (cnt_d_o),
        .o_reached_nxt (w_d_reached)
    );

    // Job FSM with latched configuration and registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= CTRL_IDLE;
            r_len        <= LEN_ZERO;
            r_nout       <= LEN_ZERO;
            r_simple_mul <= 1'b0;
            r_shift      <= SHIFT_ZERO;
            r_eng_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_evt_done   <= 1'b0;
        end else if (clear_i) begin
            r_state     <= CTRL_IDLE;
            r_eng_start <= 1'b0;
            r_busy      <= 1'b0;
            r_evt_done  <= 1'b0;
        end else begin
            r_evt_done <= 1'b0;
            case (r_state)
                CTRL_IDLE: begin
                    if (cfg_start_i) begin
                        r_len        <= cfg_len_i;
                        r_nout       <= cfg_nout_i;
                        r_simple_mul <= cfg_simple_mul_i;
                        r_shift      <= cfg_shift_i;
                        r_busy       <= 1'b1;
                        r_state      <= CTRL_WAIT_STRM;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                CTRL_WAIT_STRM: begin
                    // An empty job is retired from here without touching the streamers.
                    if (r_len == LEN_ZERO) begin
                        r_evt_done <= 1'b1;
                        r_state    <= CTRL_DONE;
                    end else if (strm_ready_i) begin
                        r_eng_start <= 1'b1;
                        r_state     <= CTRL_RUN;
                    end else begin
                        r_state <= CTRL_WAIT_STRM;
                    end
                end
                CTRL_RUN: begin
                    if (w_ab_reached && w_d_reached) begin
                        r_eng_start <= 1'b0;
                        r_evt_done  <= 1'b1;
                        r_state     <= CTRL_DONE;
                    end else if (w_ab_reached) begin
                        r_state <= CTRL_DRAIN;
                    end else begin
                        r_state <= CTRL_RUN;
                    end
                end
                CTRL_DRAIN: begin
                    if (w_d_reached) begin
                        r_eng_start <= 1'b0;
                        r_evt_done  <= 1'b1;
                        r_state     <= CTRL_DONE;
                    end else begin
                        r_state <= CTRL_DRAIN;
                    end
                end
                CTRL_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= CTRL_IDLE;
                end
                default: begin
                    r_eng_start <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= CTRL_IDLE;
                end
            endcase
        end
    end

    assign strm_req_o       = w_strm_req;
    assign eng_start_o      = r_eng_start;
    assign eng_simple_mul_o = r_simple_mul;
    assign eng_shift_o      = r_shift;
    assign busy_o           = r_busy;
    assign evt_done_o       = r_evt_done;

endmodule
